// File: rtl/prover_shuffle_v_ctrl.sv
// Round sequencer for prover_shuffle_v across one sumcheck pass: compute_v -> shuffle -> pergate.
// Moore outputs registered from next-state decode; one early vin_ready is buffered, protocol slips set err.
module prover_shuffle_v_ctrl #(
   parameter int ngates  = 8,
   parameter int nrounds = $clog2(ngates),
   parameter int rbits   = $clog2(nrounds)
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             start,
   input  logic             abort,
   input  logic             vin_ready,
   input  logic             shuf_ready,
   input  logic             gates_done,
   output logic             shuf_en,
   output logic             shuf_restart,
   output logic             gates_en,
   output logic [rbits-1:0] round,
   output logic             busy,
   output logic             done,
   output logic             err
);

   generate
      if (ngates < 4 || (ngates & (ngates - 1)) != 0 ||
          nrounds != $clog2(ngates) || rbits != $clog2(nrounds)) begin : g_bad_param
         $error("prover_shuffle_v_ctrl: ngates must be a power of two >= 4; nrounds and rbits are derived");
      end
   endgenerate

   localparam logic [rbits-1:0] last_round = rbits'(nrounds - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_V,
      SEN,
      SWAIT,
      GPULSE,
      WAIT_G
   } state_t;

   state_t           state, state_nxt;
   logic [rbits-1:0] round_nxt;
   logic             pend, pend_nxt;
   logic             err_nxt;
   logic             done_nxt;
   logic             accept;
   logic             viol;

   always_comb begin
      state_nxt = state;
      round_nxt = round;
      pend_nxt  = pend;
      done_nxt  = 1'b0;
      accept    = 1'b0;
      viol      = 1'b0;

      case (state)
         IDLE: begin
            pend_nxt = 1'b0;
            if (start) begin
               accept    = 1'b1;
               state_nxt = WAIT_V;
               round_nxt = '0;
               pend_nxt  = vin_ready;
            end
         end
         WAIT_V: begin
            if (vin_ready || pend) begin
               state_nxt = SEN;
               pend_nxt  = 1'b0;
            end
         end
         SEN:    state_nxt = SWAIT;
         SWAIT:  if (shuf_ready) state_nxt = GPULSE;
         GPULSE: state_nxt = WAIT_G;
         WAIT_G: begin
            if (gates_done) begin
               if (round == last_round) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = WAIT_V;
                  round_nxt = round + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A second early compute-ready while one is already buffered would be lost.
      if (vin_ready && state != IDLE && state != WAIT_V) begin
         if (pend) viol = 1'b1;
         pend_nxt = 1'b1;
      end
      if (gates_done && state != WAIT_G) viol = 1'b1;

      if (abort) begin
         state_nxt = IDLE;
         pend_nxt  = 1'b0;
         round_nxt = '0;
         done_nxt  = 1'b0;
         accept    = 1'b0;
      end

      err_nxt = (accept ? 1'b0 : err) | viol;
   end

   // shuf_en is low outside SEN so the shuffle's edge detector always sees a rising edge.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state        <= IDLE;
         round        <= '0;
         pend         <= 1'b0;
         err          <= 1'b0;
         shuf_en      <= 1'b0;
         shuf_restart <= 1'b0;
         gates_en     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         round        <= round_nxt;
         pend         <= pend_nxt;
         err          <= err_nxt;
         shuf_en      <= (state_nxt == SEN);
         shuf_restart <= (state_nxt == SEN) && (round_nxt == '0);
         gates_en     <= (state_nxt == GPULSE);
         busy         <= (state_nxt != IDLE);
         done         <= done_nxt;
      end
   end

endmodule

// File: tb/tb_prover_shuffle_v_ctrl.sv
// Directed bench for prover_shuffle_v_ctrl: table-driven nominal pass plus hand sequences.
module tb_prover_shuffle_v_ctrl;
   localparam int ngates  = 8;
   localparam int nrounds = 3;
   localparam int rbits   = 2;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   logic start = 1'b0, abort = 1'b0, vin_ready = 1'b0, shuf_ready = 1'b1, gates_done = 1'b0;
   logic shuf_en, shuf_restart, gates_en, busy, done, err;
   logic [rbits-1:0] round;

   int n_cmp = 0;
   int n_bad = 0;

   prover_shuffle_v_ctrl #(.ngates(ngates)) dut (
      .clk          (clk),
      .rstb         (rstb),
      .start        (start),
      .abort        (abort),
      .vin_ready    (vin_ready),
      .shuf_ready   (shuf_ready),
      .gates_done   (gates_done),
      .shuf_en      (shuf_en),
      .shuf_restart (shuf_restart),
      .gates_en     (gates_en),
      .round        (round),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   // {shuf_en, shuf_restart, gates_en, round[1:0], busy, done, err}
   logic [7:0] outs;
   assign outs = {shuf_en, shuf_restart, gates_en, round, busy, done, err};

   typedef struct {
      logic       start;
      logic       vin;
      logic       gd;
      logic [7:0] exp;
      logic [7:0] mask;
   } vec_t;

   localparam logic [7:0] M_ALL = 8'hFF;
   localparam logic [7:0] M_NR  = 8'b111_00_111;

   vec_t tbl [17];

   function automatic vec_t mk(input logic s, input logic v, input logic g,
                               input logic [7:0] e, input logic [7:0] m);
      vec_t t;
      t.start = s;
      t.vin   = v;
      t.gd    = g;
      t.exp   = e;
      t.mask  = m;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic go_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk1("start busy", busy, 1'b1);
      chkv("start round", 8'(round), 8'd0);
   endtask

   // Expects WAIT_V on entry and shuf_ready held high.
   task automatic do_round(input int r, input logic send_vin, input logic vin_at_done, input logic last);
      vin_ready = send_vin;
      tick();
      vin_ready = 1'b0;
      chk1($sformatf("r%0d shuf_en", r), shuf_en, 1'b1);
      chk1($sformatf("r%0d shuf_restart", r), shuf_restart, (r == 0));
      chkv($sformatf("r%0d round", r), 8'(round), 8'(r));
      tick();
      chk1($sformatf("r%0d swait shuf_en", r), shuf_en, 1'b0);
      tick();
      chk1($sformatf("r%0d gates_en", r), gates_en, 1'b1);
      tick();
      gates_done = 1'b1;
      vin_ready  = vin_at_done;
      tick();
      gates_done = 1'b0;
      vin_ready  = 1'b0;
      chk1($sformatf("r%0d done", r), done, last);
      chk1($sformatf("r%0d busy", r), busy, !last);
   endtask

   initial begin
      tbl[0]  = mk(1, 0, 0, 8'b000_00_100, M_ALL);
      tbl[1]  = mk(0, 1, 0, 8'b110_00_100, M_ALL);
      tbl[2]  = mk(0, 0, 0, 8'b000_00_100, M_ALL);
      tbl[3]  = mk(0, 0, 0, 8'b001_00_100, M_ALL);
      tbl[4]  = mk(0, 0, 0, 8'b000_00_100, M_ALL);
      tbl[5]  = mk(0, 0, 1, 8'b000_01_100, M_ALL);
      tbl[6]  = mk(0, 1, 0, 8'b100_01_100, M_ALL);
      tbl[7]  = mk(0, 0, 0, 8'b000_01_100, M_ALL);
      tbl[8]  = mk(0, 0, 0, 8'b001_01_100, M_ALL);
      tbl[9]  = mk(0, 0, 0, 8'b000_01_100, M_ALL);
      tbl[10] = mk(0, 0, 1, 8'b000_10_100, M_ALL);
      tbl[11] = mk(0, 1, 0, 8'b100_10_100, M_ALL);
      tbl[12] = mk(0, 0, 0, 8'b000_10_100, M_ALL);
      tbl[13] = mk(0, 0, 0, 8'b001_10_100, M_ALL);
      tbl[14] = mk(0, 0, 0, 8'b000_10_100, M_ALL);
      tbl[15] = mk(0, 0, 1, 8'b000_00_010, M_NR);
      tbl[16] = mk(0, 0, 0, 8'b000_00_000, M_NR);

      repeat (2) @(posedge clk);
      #1;
      chkv("reset outputs", outs, 8'd0);
      @(negedge clk) rstb = 1'b1;
      tick();
      chkv("idle after reset", outs, 8'd0);

      // Nominal pass, immediate responders
      for (int i = 0; i < 17; i++) begin
         start      = tbl[i].start;
         vin_ready  = tbl[i].vin;
         gates_done = tbl[i].gd;
         tick();
         chkv($sformatf("nominal row %0d", i), outs & tbl[i].mask, tbl[i].exp & tbl[i].mask);
      end
      start = 1'b0; vin_ready = 1'b0; gates_done = 1'b0;

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk1("abort+start busy", busy, 1'b0);

      // Pipelined shuffle: ready low 3 cycles after each shuf_en
      go_start();
      for (int r = 0; r < nrounds; r++) begin
         vin_ready = 1'b1; shuf_ready = 1'b0;
         tick();
         vin_ready = 1'b0;
         chk1($sformatf("pipe r%0d shuf_en", r), shuf_en, 1'b1);
         chk1($sformatf("pipe r%0d restart", r), shuf_restart, (r == 0));
         for (int k = 0; k < 4; k++) begin
            tick();
            chk1($sformatf("pipe r%0d early gates_en %0d", r, k), gates_en, 1'b0);
         end
         shuf_ready = 1'b1;
         tick();
         shuf_ready = 1'b0;
         chk1($sformatf("pipe r%0d gates_en", r), gates_en, 1'b1);
         tick();
         gates_done = 1'b1;
         tick();
         gates_done = 1'b0;
         chk1($sformatf("pipe r%0d done", r), done, (r == nrounds - 1));
      end
      shuf_ready = 1'b1;

      // Early vin_ready alongside round-0 gates_done
      go_start();
      do_round(0, 1'b1, 1'b1, 1'b0);
      do_round(1, 1'b0, 1'b0, 1'b0);
      do_round(2, 1'b1, 1'b0, 1'b1);
      chk1("early vin err", err, 1'b0);

      // Two vin_ready pulses during round-0 SWAIT
      go_start();
      chk1("viol start err", err, 1'b0);
      vin_ready = 1'b1; shuf_ready = 1'b0;
      tick();
      vin_ready = 1'b0;
      tick();
      vin_ready = 1'b1;
      tick();
      vin_ready = 1'b0;
      chk1("one early vin err", err, 1'b0);
      tick();
      vin_ready = 1'b1;
      tick();
      vin_ready = 1'b0;
      chk1("double early vin err", err, 1'b1);
      shuf_ready = 1'b1;
      tick();
      chk1("viol gates_en", gates_en, 1'b1);
      tick();
      gates_done = 1'b1;
      tick();
      gates_done = 1'b0;
      do_round(1, 1'b0, 1'b0, 1'b0);
      do_round(2, 1'b1, 1'b0, 1'b1);
      chk1("err sticky at done", err, 1'b1);

      // gates_done during WAIT_V
      go_start();
      chk1("start clears err", err, 1'b0);
      gates_done = 1'b1;
      tick();
      gates_done = 1'b0;
      chk1("stray gates_done err", err, 1'b1);
      chk1("stray gates_done busy", busy, 1'b1);
      do_round(0, 1'b1, 1'b0, 1'b0);
      do_round(1, 1'b1, 1'b0, 1'b0);
      do_round(2, 1'b1, 1'b0, 1'b1);
      chk1("err held through pass", err, 1'b1);

      // Abort in round-1 SWAIT
      go_start();
      chk1("start clears err again", err, 1'b0);
      do_round(0, 1'b1, 1'b0, 1'b0);
      vin_ready = 1'b1;
      tick();
      vin_ready = 1'b0;
      chk1("abort r1 shuf_en", shuf_en, 1'b1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chkv("after abort", outs, 8'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chkv($sformatf("idle after abort %0d", k), outs, 8'd0);
      end
      go_start();
      do_round(0, 1'b1, 1'b0, 1'b0);
      do_round(1, 1'b1, 1'b0, 1'b0);
      do_round(2, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset in round-1 WAIT_G
      go_start();
      do_round(0, 1'b1, 1'b0, 1'b0);
      vin_ready = 1'b1;
      tick();
      vin_ready = 1'b0;
      tick();
      tick();
      tick();
      chkv("in WAIT_G", outs, 8'b000_01_100);
      rstb = 1'b0;
      #1;
      chkv("async reset outputs", outs, 8'd0);
      @(negedge clk) rstb = 1'b1;
      tick();
      chkv("idle after mid reset", outs, 8'd0);
      go_start();
      do_round(0, 1'b1, 1'b0, 1'b0);
      do_round(1, 1'b1, 1'b0, 1'b0);
      do_round(2, 1'b1, 1'b0, 1'b1);
      chk1("clean pass err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prover_shuffle_v_ctrl.md
Name: prover_shuffle_v_ctrl

Overview:
Sequencer for prover_shuffle_v within one sumcheck pass over a circuit layer.
- For each round, waits for prover_compute_v to publish new V values, then pulses the shuffle enable (with restart on round 0) and waits for the shuffle ready.
- Then pulses the pergate array and waits for it to finish consuming.
- After the last round, signals done.
- Buffers one early compute-ready pulse and flags protocol violations.

Parameters:
ngates, 8, gates in the layer; must be a power of two, >= 4 (matches prover_shuffle_v ngates).
nrounds, $clog2(ngates), shuffle invocations per pass (derived; do not override; elaborate an error module if overridden).
rbits, $clog2(nrounds), round index width (derived; do not override).

Ports:
clk  input  1  clock
rstb  input  1  reset; asynchronous, active-low
start  input  1  begin a pass; honoured only in IDLE
abort  input  1  synchronous abort to IDLE from any state
vin_ready  input  1  one-cycle pulse: compute_v outputs valid for current round
shuf_ready  input  1  prover_shuffle_v ready (level)
gates_done  input  1  one-cycle pulse: pergate array has consumed shuffled values
shuf_en  output  1  to prover_shuffle_v en
shuf_restart  output  1  to prover_shuffle_v restart
gates_en  output  1  one-cycle pulse: shuffled v_0/v_1/v_tau valid
round  output  rbits  current round index
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at end of pass
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset: state IDLE; all outputs 0; pend = 0. Outputs are registered (Moore).
- shuf_en is 0 in every state except SEN. This guarantees a low-to-high edge for the shuffle's edge detector, whose en_dly resets to 1.
- States and transitions:
  - IDLE: start=1 & abort=0 -> WAIT_V. On this transition: round <= 0, err <= 0.
  - WAIT_V: (vin_ready | pend) -> SEN; pend <= 0.
  - SEN: shuf_en = 1 and shuf_restart = (round == 0) for exactly 1 cycle -> SWAIT.
  - SWAIT: shuf_en = 0. Samples shuf_ready starting the cycle after SEN; shuf_ready=1 -> GPULSE.
    - plstages=0: GPULSE is reached 2 cycles after SEN.
    - Pipelined shuffle: SWAIT waits as long as ready stays low.
  - GPULSE: gates_en = 1 for 1 cycle -> WAIT_G.
  - WAIT_G: on gates_done:
    - round == nrounds-1: done pulses 1 cycle in the next cycle; -> IDLE.
    - otherwise: round <= round+1; -> WAIT_V.
- Minimum per-round latency (vin_ready to gates_en, plstages=0): 3 cycles (WAIT_V -> SEN -> SWAIT -> GPULSE).
- vin_ready buffering:
  - vin_ready in any busy state other than WAIT_V sets pend.
  - vin_ready while pend=1 and not consumed that cycle sets err.
  - vin_ready in IDLE is ignored unless start is high in the same cycle; then pend is set.
- gates_done outside WAIT_G sets err and is otherwise ignored.
- start while busy is ignored (no err).
- abort: next state IDLE, pend <= 0, round <= 0, all pulses suppressed; err retained.
  - abort and start together in IDLE: abort wins, stays IDLE.
  - abort in SEN: shuf_en drops next cycle; the shuffle counter may have advanced, which is harmless because the next pass starts with restart.
- err remains set until the next accepted start; the pass continues regardless.
- round is held constant from entering WAIT_V through WAIT_G; it never exceeds nrounds-1.

Test Plan:
- Nominal pass, ngates=8 (nrounds=3), immediate responders: start; vin_ready each WAIT_V; shuf_ready tied 1; gates_done 1 cycle after gates_en -> exactly 3 shuf_en pulses, each 1 cycle wide with 0 between; shuf_restart=1 only on the first; round 0,1,2; gates_en 2 cycles after each shuf_en; done pulses once; busy falls with done; err=0.
- Pipelined shuffle model: shuf_ready low for 3 cycles after each shuf_en -> gates_en asserted exactly 1 cycle after shuf_ready rises; never earlier.
- Early vin_ready: vin_ready in the same cycle as gates_done for round 0 -> pend set; round-1 SEN follows in the next WAIT_V cycle without a further vin_ready; err=0.
- Protocol violations: two vin_ready pulses during round-0 SWAIT -> err=1, pass completes; gates_done during WAIT_V -> err=1. Next start clears err to 0.
- Abort mid-pass: abort in SWAIT of round 1 -> IDLE next cycle; busy=0, round=0, no done, no gates_en. A following start runs a full pass with shuf_restart=1 on its first shuf_en.
- Reset mid-operation: rstb low during WAIT_G -> all outputs 0 immediately (asynchronous). After release, start runs a clean 3-round pass.
